// File: rtl/arb_pkg.sv
// Shared types and sizes for the 8-way round-robin arbiter.
// Holds the FSM state encoding and requester/index widths.
package arb_pkg;

   localparam int N_REQ = 8;
   localparam int IDX_W = 3;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      RECOVER = 2'd2
   } state_t;

endpackage

// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between the requesting units and the arbiter.
// The master side drives requests and the slave (arbiter) side drives grants.
interface rr_arbiter8_if;
   import arb_pkg::*;

   logic             en;
   logic [N_REQ-1:0] req;
   logic [N_REQ-1:0] gnt;
   logic [IDX_W-1:0] gnt_idx;
   logic             gnt_valid;
   logic             timeout;

   modport master (
      output en, req,
      input  gnt, gnt_idx, gnt_valid, timeout
   );

   modport slave (
      input  en, req,
      output gnt, gnt_idx, gnt_valid, timeout
   );

endinterface

// File: rtl/onehot_dec3.sv
// Purpose: 3-to-8 one-hot decode of a binary index.
// Latency: combinational. Backpressure: none.
module onehot_dec3
   import arb_pkg::*;
(
   input  logic [IDX_W-1:0] idx,
   output logic [N_REQ-1:0] onehot
);

   always_comb begin
      onehot      = '0;
      onehot[idx] = 1'b1;
   end

endmodule

// File: rtl/rr_arbiter8.sv
// Purpose: round-robin grant of one shared select resource to eight requesters.
// Latency: grant registered one edge after request; owner holds until release or MAX_HOLD, then a dead cycle.
module rr_arbiter8
   import arb_pkg::*;
#(
   parameter int MAX_HOLD = 16
)(
   input  logic           clk,
   input  logic           rst_n,
   rr_arbiter8_if.slave   bus
);

   localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

   state_t           state_q, state_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [HW-1:0]    hold_q, hold_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             vld_q, vld_d;
   logic             tmo_q, tmo_d;
   logic [IDX_W-1:0] win;
   logic [N_REQ-1:0] win_oh;

   // First set request at or above p, wrapping modulo N_REQ.
   function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                input logic [IDX_W-1:0] p);
      logic [IDX_W-1:0] cand;
      logic             found;
      rr_pick = p;
      found   = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         cand = p + IDX_W'(i);
         if (!found && r[cand]) begin
            rr_pick = cand;
            found   = 1'b1;
         end
      end
   endfunction

   assign win = rr_pick(bus.req, ptr_q);

   onehot_dec3 u_dec (
      .idx    (win),
      .onehot (win_oh)
   );

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      hold_d  = hold_q;
      gnt_d   = gnt_q;
      idx_d   = idx_q;
      vld_d   = vld_q;
      tmo_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.en && (|bus.req)) begin
               gnt_d   = win_oh;
               idx_d   = win;
               vld_d   = 1'b1;
               hold_d  = '0;
               ptr_d   = win + IDX_W'(1);
               state_d = GRANT;
            end
         end
         GRANT: begin
            // Release wins over timeout, so timeout only fires on a still-held grant.
            if (!bus.req[idx_q] || (hold_q == HOLD_LAST)) begin
               gnt_d   = '0;
               idx_d   = '0;
               vld_d   = 1'b0;
               tmo_d   = bus.req[idx_q];
               state_d = RECOVER;
            end else begin
               hold_d = hold_q + HW'(1);
            end
         end
         RECOVER: state_d = IDLE;
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
            idx_d   = '0;
            vld_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         hold_q  <= '0;
         gnt_q   <= '0;
         idx_q   <= '0;
         vld_q   <= 1'b0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         hold_q  <= hold_d;
         gnt_q   <= gnt_d;
         idx_q   <= idx_d;
         vld_q   <= vld_d;
         tmo_q   <= tmo_d;
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.gnt_idx   = idx_q;
   assign bus.gnt_valid = vld_q;
   assign bus.timeout   = tmo_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Vector-table bench for rr_arbiter8 with MAX_HOLD=4; expected outputs queued at drive time.
module tb_rr_arbiter8;
   import arb_pkg::*;

   localparam int MH = 4;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   rr_arbiter8_if bus();

   rr_arbiter8 #(.MAX_HOLD(MH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic       en;
      logic [7:0] req;
      logic [7:0] gnt;
      logic [2:0] idx;
      logic       vld;
      logic       tmo;
   } vec_t;

   typedef struct packed {
      logic [7:0] gnt;
      logic [2:0] idx;
      logic       vld;
      logic       tmo;
   } exp_t;

   vec_t vecs[$];
   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;

   function automatic exp_t mk(input int owner, input logic tmo);
      exp_t e;
      e.gnt = (owner >= 0) ? (8'h01 << owner) : 8'h00;
      e.idx = (owner >= 0) ? 3'(owner) : 3'd0;
      e.vld = (owner >= 0);
      e.tmo = tmo;
      return e;
   endfunction

   function automatic void add(input logic en, input logic [7:0] req, input int owner, input logic tmo);
      vec_t v;
      exp_t e;
      e     = mk(owner, tmo);
      v.en  = en;
      v.req = req;
      v.gnt = e.gnt;
      v.idx = e.idx;
      v.vld = e.vld;
      v.tmo = e.tmo;
      vecs.push_back(v);
   endfunction

   function automatic exp_t actual();
      exp_t a;
      a.gnt = bus.gnt;
      a.idx = bus.gnt_idx;
      a.vld = bus.gnt_valid;
      a.tmo = bus.timeout;
      return a;
   endfunction

   task automatic check(input string nm, input exp_t act, input exp_t exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got gnt=%h idx=%0d vld=%b tmo=%b, want gnt=%h idx=%0d vld=%b tmo=%b",
                  nm, act.gnt, act.idx, act.vld, act.tmo, exp.gnt, exp.idx, exp.vld, exp.tmo);
      end
   endtask

   // Drive one cycle of inputs, queue its expectation, compare after the edge.
   task automatic step(input logic en, input logic [7:0] req, input exp_t e, input string nm);
      exp_t x;
      @(negedge clk);
      bus.en  = en;
      bus.req = req;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         tests++;
         fails++;
         $display("FAIL %s: scoreboard empty", nm);
      end else begin
         x = exp_q.pop_front();
         check(nm, actual(), x);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1);
   end

   initial begin
      // Single request, grant, immediate release, dead cycles.
      add(1, 8'h10, 4, 0);
      add(1, 8'h00, -1, 0);
      add(1, 8'h00, -1, 0);
      add(1, 8'h00, -1, 0);
      // All requesting: pointer sits at 5, so order 5,6,7,0,..,5 with timeouts.
      for (int k = 0; k < 9; k++) begin
         for (int c = 0; c < MH; c++) add(1, 8'hFF, (5 + k) % 8, 0);
         add(1, 8'hFF, -1, 1);
         add(1, 8'hFF, -1, 0);
      end
      // Pointer wrap: winner 6, then 8'h41 gives 0, then 6 again.
      add(1, 8'h40, 6, 0);
      add(1, 8'h00, -1, 0);
      add(1, 8'h00, -1, 0);
      add(1, 8'h41, 0, 0);
      add(1, 8'h40, -1, 0);
      add(1, 8'h41, -1, 0);
      add(1, 8'h41, 6, 0);
      for (int c = 1; c < MH; c++) add(1, 8'h41, 6, 0);
      // Release in the same cycle the hold limit is reached: no timeout.
      add(1, 8'h01, -1, 0);
      add(1, 8'h00, -1, 0);
      add(1, 8'h00, -1, 0);
      // en low keeps a live grant and blocks new ones.
      add(1, 8'h08, 3, 0);
      add(0, 8'h08, 3, 0);
      add(0, 8'h08, 3, 0);
      add(0, 8'h00, -1, 0);
      add(0, 8'h08, -1, 0);
      add(0, 8'h08, -1, 0);
      add(0, 8'h08, -1, 0);
      add(1, 8'h08, 3, 0);
      add(1, 8'h00, -1, 0);
      add(1, 8'h00, -1, 0);

      rst_n   = 1'b0;
      bus.en  = 1'b1;
      bus.req = 8'hFF;
      repeat (2) @(posedge clk);
      #1;
      check("reset_state", actual(), mk(-1, 0));
      @(negedge clk);
      bus.req = 8'h00;
      rst_n   = 1'b1;

      for (int i = 0; i < vecs.size(); i++)
         step(vecs[i].en, vecs[i].req,
              {vecs[i].gnt, vecs[i].idx, vecs[i].vld, vecs[i].tmo},
              $sformatf("vec%0d", i));

      // Asynchronous reset in the middle of a grant to requester 5.
      step(1, 8'h20, mk(5, 0), "rst_pre_grant");
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_async_clear", actual(), mk(-1, 0));
      bus.req = 8'h00;
      @(negedge clk);
      rst_n = 1'b1;
      step(1, 8'h21, mk(0, 0), "rst_ptr_zero");
      step(1, 8'h20, mk(-1, 0), "rst_post_release");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
